asrv32_pipeline_ctrl: RTL and testbench
=======================================

Name: asrv32_pipeline_ctrl

Overview:
Central sequencer for the 5-stage ASRV32 pipeline (fetch, decode, ALU, memory access, writeback).
- Owns the per-stage valid/clock-enable registers that operand forwarding consumes as stage-4/stage-5 enables.
- Derives backward-propagating stall signals and applies branch/jump flushes.
- Holds fetch for a programmable number of cycles after reset.

Parameters:
RESET_HOLD, 2, cycles fetch is held stalled after reset deasserts (0 = no hold)
CNT_W, 32, width of optional performance counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_fetch_valid  in  1  fetch stage presents an instruction this cycle
i_fetch_wait  in  1  instruction memory not ready; fetch cannot deliver
i_alu_force_stall  in  1  operand forwarding requests ALU hold (load/CSR use)
i_alu_flush  in  1  ALU resolved taken branch/jump/trap redirect
i_mem_busy  in  1  data memory access in memory-access stage not complete
o_decoder_ce  out  1  decode stage holds valid instruction
o_alu_ce  out  1  ALU stage holds valid instruction
o_memoryaccess_ce  out  1  memory-access stage holds valid instruction
o_writeback_ce  out  1  writeback stage holds valid instruction
o_fetch_stall  out  1  fetch must not advance PC
o_decoder_stall  out  1  decode must hold its registers
o_alu_stall  out  1  ALU must hold its registers
o_memoryaccess_stall  out  1  memory-access must hold its registers
o_fetch_flush  out  1  redirect fetch; discard in-flight fetch

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_rst.
- Registered state: v_dec, v_alu, v_mem, v_wb (drive the four *_ce outputs); hold counter hcnt.
- Reset: all v_* = 0; hcnt = RESET_HOLD; o_fetch_stall = 1 while hcnt != 0; other combinational outputs follow the equations below (all 0 with empty pipe).
- Combinational stalls, computed downstream first:
  - stall_mem = v_mem & i_mem_busy
  - stall_alu = v_alu & (i_alu_force_stall | stall_mem)
  - stall_dec = v_dec & stall_alu
  - o_fetch_stall = i_fetch_wait | stall_dec | (hcnt != 0)
- Effective flush: flush = i_alu_flush & v_alu & !stall_alu. A flush raised while the ALU is stalled is ignored; the ALU re-asserts it once released. o_fetch_flush = flush.
- Next state, priority reset > flush > stall:
  - v_dec' = flush ? 0 : stall_dec ? v_dec : (i_fetch_valid & !o_fetch_stall)
  - v_alu' = flush ? 0 : stall_alu ? v_alu : (v_dec & !stall_dec)
  - v_mem' = stall_mem ? v_mem : (v_alu & !stall_alu); the flushing instruction itself advances
  - v_wb' = v_mem & !stall_mem; writeback never stalls
- Hold counter: hcnt decrements by 1 per cycle to 0 and saturates; it cannot be restarted except by reset.
- A stage stalled by its own condition emits a bubble (next stage valid = 0). A load producing a force stall therefore moves to writeback while the consumer waits, after which writeback forwarding resolves the hazard.
- Stall inputs are ignored when their stage is invalid (qualified by v_*).
- Reset asserted mid-operation: all in-flight instructions are dropped next edge, no writeback. Any flush pending in the same cycle is discarded.
- Latency: an instruction accepted from fetch at edge N is in writeback at edge N+3 with no stalls.
- All outputs are glitch-tolerant combinational or direct registers; no combinational path from *_ce outputs back to inputs.

Optional Feature:
ASRV32_PIPE_PERF_EN
- Defined: adds outputs o_stall_cycles[CNT_W-1:0] and o_flush_count[CNT_W-1:0].
  - o_stall_cycles increments each cycle stall_alu | stall_dec is 1.
  - o_flush_count increments on each effective flush.
  - Both reset to 0 and wrap at 2^CNT_W to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Add to asrv32_header.vh: stage index constants (STAGE_FETCH..STAGE_WB = 0..4) and the RESET_HOLD default.
- No sub-module required. Optional: asrv32_sat_counter for the hold counter if reused elsewhere; a flat single module is acceptable.

Test Plan:
- Reset release, RESET_HOLD=2, i_fetch_valid=1 constant -> o_fetch_stall=1 for 2 cycles after reset, then v_dec=1 on 3rd edge and o_writeback_ce=1 three edges later.
- Steady stream, i_alu_force_stall=1 for 1 cycle with v_alu=1 -> o_alu_stall=o_decoder_stall=o_fetch_stall=1 that cycle; next cycle o_memoryaccess_ce=0 (bubble), o_alu_ce still 1.
- i_mem_busy=1 for 3 cycles with full pipe -> all upstream stages hold for 3 cycles, o_writeback_ce=0 for cycles 2-4, v_* unchanged; resumes without loss.
- i_alu_flush=1 with full pipe -> o_fetch_flush=1; next edge o_decoder_ce=0, o_alu_ce=0, o_memoryaccess_ce=1.
- i_alu_flush=1 and i_alu_force_stall=1 same cycle -> o_fetch_flush=0, no invalidation; flush honoured the cycle the stall drops.
- i_rst=1 mid-stream with i_mem_busy=1 -> all *_ce=0 next edge, hold counter reloaded to 2; with ASRV32_PIPE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/asrv32_pipeline_ctrl_pkg.sv
// Shared constants for the ASRV32 pipeline controller: stage indices and parameter defaults.
package asrv32_pipeline_ctrl_pkg;

    localparam int unsigned STAGE_FETCH  = 0;
    localparam int unsigned STAGE_DECODE = 1;
    localparam int unsigned STAGE_ALU    = 2;
    localparam int unsigned STAGE_MEM    = 3;
    localparam int unsigned STAGE_WB     = 4;

    localparam int unsigned RESET_HOLD_DEFAULT = 2;
    localparam int unsigned CNT_W_DEFAULT      = 32;

    // Width able to hold the reset-hold count; at least one bit even when the hold is disabled.
    function automatic int unsigned hold_width(input int unsigned hold);
        return (hold == 0) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/asrv32_pipeline_ctrl_if.sv
// Stage handshake bundle between the pipeline datapath (master) and its controller (slave).
// ASRV32_PIPE_PERF_EN adds the stall/flush performance counter outputs.
interface asrv32_pipeline_ctrl_if
    import asrv32_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic i_fetch_valid;
    logic i_fetch_wait;
    logic i_alu_force_stall;
    logic i_alu_flush;
    logic i_mem_busy;
    logic o_decoder_ce;
    logic o_alu_ce;
    logic o_memoryaccess_ce;
    logic o_writeback_ce;
    logic o_fetch_stall;
    logic o_decoder_stall;
    logic o_alu_stall;
    logic o_memoryaccess_stall;
    logic o_fetch_flush;
`ifdef ASRV32_PIPE_PERF_EN
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_flush_count;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

    modport master (
        output i_fetch_valid, i_fetch_wait, i_alu_force_stall, i_alu_flush, i_mem_busy,
        input  o_decoder_ce, o_alu_ce, o_memoryaccess_ce, o_writeback_ce,
        input  o_fetch_stall, o_decoder_stall, o_alu_stall, o_memoryaccess_stall,
        input  o_fetch_flush
`ifdef ASRV32_PIPE_PERF_EN
        , input o_stall_cycles, o_flush_count
`endif
    );

    modport slave (
        input  i_fetch_valid, i_fetch_wait, i_alu_force_stall, i_alu_flush, i_mem_busy,
        output o_decoder_ce, o_alu_ce, o_memoryaccess_ce, o_writeback_ce,
        output o_fetch_stall, o_decoder_stall, o_alu_stall, o_memoryaccess_stall,
        output o_fetch_flush
`ifdef ASRV32_PIPE_PERF_EN
        , output o_stall_cycles, o_flush_count
`endif
    );

endinterface

// File: rtl/asrv32_pipeline_ctrl.sv
// ASRV32 5-stage pipeline sequencer: stage valids, backward stalls, branch flush, reset fetch hold.
// ASRV32_PIPE_PERF_EN adds stall-cycle and flush counters.
module asrv32_pipeline_ctrl
    import asrv32_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOLD = RESET_HOLD_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    asrv32_pipeline_ctrl_if.slave bus
);
    localparam int unsigned HoldW = hold_width(RESET_HOLD);

    logic             v_dec_q, v_dec_d;
    logic             v_alu_q, v_alu_d;
    logic             v_mem_q, v_mem_d;
    logic             v_wb_q, v_wb_d;
    logic [HoldW-1:0] hcnt_q, hcnt_d;
    logic             stall_mem, stall_alu, stall_dec, fetch_stall, flush, hold_active;

    always_comb begin
        hold_active = (hcnt_q != '0);
        stall_mem   = v_mem_q & bus.i_mem_busy;
        stall_alu   = v_alu_q & (bus.i_alu_force_stall | stall_mem);
        stall_dec   = v_dec_q & stall_alu;
        fetch_stall = bus.i_fetch_wait | stall_dec | hold_active;
        // A flush from a stalled ALU is dropped; the ALU re-raises it once released.
        flush       = bus.i_alu_flush & v_alu_q & ~stall_alu;

        v_dec_d = flush ? 1'b0 : stall_dec ? v_dec_q : (bus.i_fetch_valid & ~fetch_stall);
        v_alu_d = flush ? 1'b0 : stall_alu ? v_alu_q : (v_dec_q & ~stall_dec);
        v_mem_d = stall_mem ? v_mem_q : (v_alu_q & ~stall_alu);
        v_wb_d  = v_mem_q & ~stall_mem;
        hcnt_d  = hold_active ? hcnt_q - HoldW'(1) : hcnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_dec_q <= 1'b0;
            v_alu_q <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
            hcnt_q  <= HoldW'(RESET_HOLD);
        end else begin
            v_dec_q <= v_dec_d;
            v_alu_q <= v_alu_d;
            v_mem_q <= v_mem_d;
            v_wb_q  <= v_wb_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign bus.o_decoder_ce         = v_dec_q;
    assign bus.o_alu_ce             = v_alu_q;
    assign bus.o_memoryaccess_ce    = v_mem_q;
    assign bus.o_writeback_ce       = v_wb_q;
    assign bus.o_fetch_stall        = fetch_stall;
    assign bus.o_decoder_stall      = stall_dec;
    assign bus.o_alu_stall          = stall_alu;
    assign bus.o_memoryaccess_stall = stall_mem;
    assign bus.o_fetch_flush        = flush;

`ifdef ASRV32_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + ((stall_alu | stall_dec) ? CNT_W'(1) : CNT_W'(0));
        flush_count_d  = flush_count_q + (flush ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.o_stall_cycles = stall_cycles_q;
    assign bus.o_flush_count  = flush_count_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_asrv32_pipeline_ctrl.sv
// Bench for asrv32_pipeline_ctrl: directed vector table, then randomised stimulus against a model.
module tb_asrv32_pipeline_ctrl;
    import asrv32_pipeline_ctrl_pkg::*;

    // {rst, fetch_valid, fetch_wait, force_stall, flush, mem_busy}, ce {dec,alu,mem,wb},
    // stalls {fetch,dec,alu,mem}, fetch_flush
    typedef struct packed {
        logic [5:0] in;
        logic [3:0] ce;
        logic [3:0] st;
        logic       fl;
    } vec_t;

    typedef struct {
        logic [3:0]  ce;
        logic [3:0]  st;
        logic        fl;
        logic        perf;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    localparam int NVEC = 26;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    vec_t tbl[NVEC];

    asrv32_pipeline_ctrl_if #(.CNT_W(32)) u_if ();

    asrv32_pipeline_ctrl #(
        .RESET_HOLD(2),
        .CNT_W     (32)
    ) u_dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (u_if.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [5:0] in);
        {i_rst, u_if.i_fetch_valid, u_if.i_fetch_wait, u_if.i_alu_force_stall,
         u_if.i_alu_flush, u_if.i_mem_busy} = in;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " ce"}, {28'd0, u_if.o_decoder_ce, u_if.o_alu_ce,
              u_if.o_memoryaccess_ce, u_if.o_writeback_ce}, {28'd0, e.ce});
        check({tag, " stall"}, {28'd0, u_if.o_fetch_stall, u_if.o_decoder_stall,
              u_if.o_alu_stall, u_if.o_memoryaccess_stall}, {28'd0, e.st});
        check({tag, " flush"}, {31'd0, u_if.o_fetch_flush}, {31'd0, e.fl});
`ifdef ASRV32_PIPE_PERF_EN
        if (e.perf) begin
            check({tag, " stall_cycles"}, u_if.o_stall_cycles, e.sc);
            check({tag, " flush_count"}, u_if.o_flush_count, e.fc);
        end
`endif
    endtask

    initial begin
        logic [3:0]  mv;
        int          mh;
        logic [31:0] msc, mfc;
        logic        perf_known;

        tbl[0]  = {6'b010000, 4'b0000, 4'b1000, 1'b0};
        tbl[1]  = {6'b010000, 4'b0000, 4'b1000, 1'b0};
        tbl[2]  = {6'b010000, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = {6'b010000, 4'b1000, 4'b0000, 1'b0};
        tbl[4]  = {6'b010000, 4'b1100, 4'b0000, 1'b0};
        tbl[5]  = {6'b010000, 4'b1110, 4'b0000, 1'b0};
        tbl[6]  = {6'b010100, 4'b1111, 4'b1110, 1'b0};
        tbl[7]  = {6'b010000, 4'b1101, 4'b0000, 1'b0};
        tbl[8]  = {6'b010001, 4'b1110, 4'b1111, 1'b0};
        tbl[9]  = {6'b010001, 4'b1110, 4'b1111, 1'b0};
        tbl[10] = {6'b010001, 4'b1110, 4'b1111, 1'b0};
        tbl[11] = {6'b010000, 4'b1110, 4'b0000, 1'b0};
        tbl[12] = {6'b010010, 4'b1111, 4'b0000, 1'b1};
        tbl[13] = {6'b010000, 4'b0011, 4'b0000, 1'b0};
        tbl[14] = {6'b010000, 4'b1001, 4'b0000, 1'b0};
        tbl[15] = {6'b010000, 4'b1100, 4'b0000, 1'b0};
        tbl[16] = {6'b010110, 4'b1110, 4'b1110, 1'b0};
        tbl[17] = {6'b010010, 4'b1101, 4'b0000, 1'b1};
        tbl[18] = {6'b010000, 4'b0010, 4'b0000, 1'b0};
        tbl[19] = {6'b010001, 4'b1001, 4'b0000, 1'b0};
        tbl[20] = {6'b011000, 4'b1100, 4'b1000, 1'b0};
        tbl[21] = {6'b010000, 4'b0110, 4'b0000, 1'b0};
        tbl[22] = {6'b110001, 4'b1011, 4'b0001, 1'b0};
        tbl[23] = {6'b010000, 4'b0000, 4'b1000, 1'b0};
        tbl[24] = {6'b010000, 4'b0000, 4'b1000, 1'b0};
        tbl[25] = {6'b010000, 4'b0000, 4'b0000, 1'b0};

        apply(6'b100000);
        repeat (2) @(posedge i_clk);

        for (int i = 0; i < NVEC; i++) begin
            exp_t e;
            @(posedge i_clk);
            #1;
            apply(tbl[i].in);
            e.ce = tbl[i].ce; e.st = tbl[i].st; e.fl = tbl[i].fl;
            e.perf = (i == 23); e.sc = 32'd0; e.fc = 32'd0;
            exp_q.push_back(e);
            @(negedge i_clk);
            compare($sformatf("vec%0d", i));
        end

        // Model state left by the last table row.
        mv = 4'b1000; mh = 0; msc = 0; mfc = 0; perf_known = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [5:0] in;
            logic sm, sa, sd, fst, fe;
            exp_t e;
            in[5] = (c == 0) || ($urandom_range(0, 39) == 0);
            in[4] = ($urandom_range(0, 7) != 0);
            in[3] = ($urandom_range(0, 5) == 0);
            in[2] = ($urandom_range(0, 4) == 0);
            in[1] = ($urandom_range(0, 6) == 0);
            in[0] = ($urandom_range(0, 3) == 0);
            sm  = mv[1] & in[0];
            sa  = mv[2] & (in[2] | sm);
            sd  = mv[3] & sa;
            fst = in[3] | sd | (mh != 0);
            fe  = in[1] & mv[2] & ~sa;
            @(posedge i_clk);
            #1;
            apply(in);
            e.ce = mv; e.st = {fst, sd, sa, sm}; e.fl = fe;
            e.perf = perf_known; e.sc = msc; e.fc = mfc;
            exp_q.push_back(e);
            @(negedge i_clk);
            compare($sformatf("rnd%0d", c));
            if (in[5]) begin
                mv = 4'b0000; mh = 2; msc = 0; mfc = 0; perf_known = 1'b1;
            end else begin
                mv = {fe ? 1'b0 : sd ? mv[3] : (in[4] & ~fst),
                      fe ? 1'b0 : sa ? mv[2] : (mv[3] & ~sd),
                      sm ? mv[1] : (mv[2] & ~sa),
                      mv[1] & ~sm};
                if (mh != 0) mh--;
                if (sa | sd) msc++;
                if (fe) mfc++;
            end
        end

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
